// File: rtl/text_buffer_ctrl.sv
// Character text buffer with cursor, control-code decode, scroll and clear.
// Display rows map to physical rows through a rotating top pointer.
module text_buffer_ctrl #(
    parameter int COLS   = 32,
    parameter int ROWS   = 4,
    parameter int SCROLL = 1,
    localparam int CW    = $clog2(COLS),
    localparam int RW    = $clog2(ROWS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_valid,
    input  logic [7:0]    wr_data,
    output logic          wr_ready,
    input  logic          clr,
    input  logic [RW-1:0] rd_row,
    input  logic [CW-1:0] rd_col,
    output logic [7:0]    rd_data,
    output logic [RW-1:0] cur_row,
    output logic [CW-1:0] cur_col,
    output logic [7:0]    last_char,
    output logic          busy
);

    localparam int AW = $clog2(COLS * ROWS);
    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] FILL_ROW = 2'd1;
    localparam logic [1:0] FILL_ALL = 2'd2;
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [RW:0]   ROWS_W  = ROWS[RW:0];

    logic [1:0]    state_q, state_d;
    logic [RW-1:0] cur_row_q, cur_row_d;
    logic [CW-1:0] cur_col_q, cur_col_d;
    logic [RW-1:0] top_q, top_d;
    logic [7:0]    last_q, last_d;
    logic [RW-1:0] fill_row_q, fill_row_d;
    logic [CW-1:0] fill_col_q, fill_col_d;
    logic [7:0]    rd_data_q, rd_data_d;
    logic          live_q;

    logic [7:0]    mem [COLS*ROWS];
    logic          we;
    logic [AW-1:0] waddr;
    logic [7:0]    wdata;
    logic          lf;
    logic          accept;
    logic          printable;
    logic [RW-1:0] prow;

    function automatic logic [RW-1:0] phys(input logic [RW-1:0] r,
                                           input logic [RW-1:0] t);
        logic [RW:0] s;
        s = {1'b0, r} + {1'b0, t};
        if (s >= ROWS_W) s = s - ROWS_W;
        return s[RW-1:0];
    endfunction

    function automatic logic [AW-1:0] addr(input logic [RW-1:0] r,
                                           input logic [CW-1:0] c);
        return AW'(r) * AW'(COLS) + AW'(c);
    endfunction

    assign busy      = (state_q != IDLE);
    assign wr_ready  = !busy;
    assign cur_row   = cur_row_q;
    assign cur_col   = cur_col_q;
    assign last_char = last_q;
    assign rd_data   = rd_data_q;

    assign prow      = phys(cur_row_q, top_q);
    assign accept    = live_q && wr_valid && !busy && !clr;
    assign printable = (wr_data >= 8'h20) && (wr_data <= 8'h7E);
    assign rd_data_d = mem[addr(phys(rd_row, top_q), rd_col)];

    always_comb begin
        state_d    = state_q;
        cur_row_d  = cur_row_q;
        cur_col_d  = cur_col_q;
        top_d      = top_q;
        last_d     = last_q;
        fill_row_d = fill_row_q;
        fill_col_d = fill_col_q;
        we         = 1'b0;
        waddr      = addr(prow, cur_col_q);
        wdata      = wr_data;
        lf         = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (live_q && clr) begin
                    state_d    = FILL_ALL;
                    fill_row_d = '0;
                    fill_col_d = '0;
                end else if (accept) begin
                    last_d = wr_data;
                    unique case (1'b1)
                        printable: begin
                            we = 1'b1;
                            if (cur_col_q == COL_MAX) begin
                                cur_col_d = '0;
                                lf        = 1'b1;
                            end else begin
                                cur_col_d = cur_col_q + 1'b1;
                            end
                        end
                        (wr_data == 8'h0D): cur_col_d = '0;
                        // Line feed is a full newline: column returns to 0.
                        (wr_data == 8'h0A): begin
                            cur_col_d = '0;
                            lf        = 1'b1;
                        end
                        (wr_data == 8'h08): begin
                            if (cur_col_q != '0) begin
                                cur_col_d = cur_col_q - 1'b1;
                                we        = 1'b1;
                                wdata     = 8'h20;
                                waddr     = addr(prow, cur_col_q - 1'b1);
                            end
                        end
                        default: ;
                    endcase
                    if (lf) begin
                        if (cur_row_q != ROW_MAX) begin
                            cur_row_d = cur_row_q + 1'b1;
                        end else if (SCROLL != 0) begin
                            // Old top row becomes the new bottom row.
                            top_d      = (top_q == ROW_MAX) ? '0 : top_q + 1'b1;
                            fill_row_d = top_q;
                            fill_col_d = '0;
                            state_d    = FILL_ROW;
                        end else begin
                            cur_row_d = '0;
                        end
                    end
                end
            end
            FILL_ROW: begin
                we    = 1'b1;
                wdata = 8'h20;
                waddr = addr(fill_row_q, fill_col_q);
                if (fill_col_q == COL_MAX) begin
                    fill_col_d = '0;
                    state_d    = IDLE;
                end else begin
                    fill_col_d = fill_col_q + 1'b1;
                end
            end
            FILL_ALL: begin
                we    = 1'b1;
                wdata = 8'h20;
                waddr = addr(fill_row_q, fill_col_q);
                if (fill_col_q == COL_MAX) begin
                    fill_col_d = '0;
                    if (fill_row_q == ROW_MAX) begin
                        fill_row_d = '0;
                        state_d    = IDLE;
                        top_d      = '0;
                        cur_row_d  = '0;
                        cur_col_d  = '0;
                    end else begin
                        fill_row_d = fill_row_q + 1'b1;
                    end
                end else begin
                    fill_col_d = fill_col_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cur_row_q  <= '0;
            cur_col_q  <= '0;
            top_q      <= '0;
            last_q     <= 8'h00;
            fill_row_q <= '0;
            fill_col_q <= '0;
            rd_data_q  <= 8'h00;
            live_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_row_q  <= cur_row_d;
            cur_col_q  <= cur_col_d;
            top_q      <= top_d;
            last_q     <= last_d;
            fill_row_q <= fill_row_d;
            fill_col_q <= fill_col_d;
            rd_data_q  <= rd_data_d;
            live_q     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Directed scoreboard bench for text_buffer_ctrl, scroll and wrap instances.
module tb_text_buffer_ctrl;

    localparam int COLS = 32;
    localparam int ROWS = 4;
    localparam int CW   = 5;
    localparam int RW   = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          wr_valid = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          clr = 1'b0;
    logic [RW-1:0] rd_row = '0;
    logic [CW-1:0] rd_col = '0;

    logic          s_wr_ready, w_wr_ready;
    logic [7:0]    s_rd_data, w_rd_data;
    logic [RW-1:0] s_cur_row, w_cur_row;
    logic [CW-1:0] s_cur_col, w_cur_col;
    logic [7:0]    s_last_char, w_last_char;
    logic          s_busy, w_busy;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    text_buffer_ctrl #(.COLS(COLS), .ROWS(ROWS), .SCROLL(1)) u_s (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(s_wr_ready), .clr(clr), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data(s_rd_data), .cur_row(s_cur_row), .cur_col(s_cur_col),
        .last_char(s_last_char), .busy(s_busy)
    );

    text_buffer_ctrl #(.COLS(COLS), .ROWS(ROWS), .SCROLL(0)) u_w (
        .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_ready(w_wr_ready), .clr(clr), .rd_row(rd_row), .rd_col(rd_col),
        .rd_data(w_rd_data), .cur_row(w_cur_row), .cur_col(w_cur_col),
        .last_char(w_last_char), .busy(w_busy)
    );

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_chk++;
        if (exp_q.size() == 0) begin
            $error("FAIL %s: got %0h, no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) n_pass++;
            else $error("FAIL %s: got %0h want %0h", tag, obs, e);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        wr_valid = 1'b1;
        wr_data  = b;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic rd(input int r, input int c);
        @(negedge clk);
        rd_row = RW'(r);
        rd_col = CW'(c);
        @(negedge clk);
    endtask

    task automatic busy_len(output int ns, output int nw, output int nrdy);
        int n;
        ns = 0; nw = 0; nrdy = 0; n = 0;
        while ((s_busy || w_busy) && n < 1000) begin
            if (s_busy) ns++;
            if (w_busy) nw++;
            if (s_busy && s_wr_ready) nrdy++;
            n++;
            @(negedge clk);
        end
    endtask

    task automatic scan_s(output int bad);
        bad = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                rd(r, c);
                if (s_rd_data !== 8'h20) bad++;
            end
    endtask

    initial begin
        int ns, nw, nr, nb, bad;
        repeat (3) @(negedge clk);
        push(0);  check("rst_row", s_cur_row);
        push(0);  check("rst_col", s_cur_col);
        push(0);  check("rst_last", s_last_char);
        push(0);  check("rst_busy", s_busy);
        push(1);  check("rst_ready", s_wr_ready);
        push(0);  check("rst_rd", s_rd_data);

        reset = 1'b1; wr_valid = 1'b1; wr_data = 8'h41;
        @(negedge clk); @(negedge clk);
        wr_valid = 1'b0;
        push(1);  check("rel_col", s_cur_col);

        send(8'h42);
        push(0);  check("ab_row", s_cur_row);
        push(2);  check("ab_col", s_cur_col);
        push(8'h42); check("ab_last", s_last_char);
        rd(0, 0); push(8'h41); check("ab_rd00", s_rd_data);
        rd(0, 1); push(8'h42); check("ab_rd01", s_rd_data);

        send(8'h08);
        push(1);  check("bs_col", s_cur_col);
        rd(0, 1); push(8'h20); check("bs_rd01", s_rd_data);
        send(8'h0D);
        push(0);  check("cr_col", s_cur_col);
        rd(0, 0); push(8'h41); check("cr_rd00", s_rd_data);
        send(8'h08);
        push(0);  check("bs0_col", s_cur_col);
        push(0);  check("bs0_row", s_cur_row);
        push(8'h08); check("bs0_last", s_last_char);
        rd(0, 0); push(8'h41); check("bs0_rd00", s_rd_data);
        send(8'h01);
        push(0);  check("ctl_col", s_cur_col);
        push(8'h01); check("ctl_last", s_last_char);

        @(negedge clk);
        rd_row = 0; rd_col = 0; wr_valid = 1'b1; wr_data = 8'h30;
        @(negedge clk);
        wr_valid = 1'b0;
        push(8'h41); check("rd_old", s_rd_data);
        @(negedge clk);
        push(8'h30); check("rd_new", s_rd_data);
        nb = 0;
        for (int i = 1; i < COLS; i++) begin
            send(8'(8'h30 + i));
            if (s_busy) nb++;
        end
        push(0);  check("wrap_busy", nb);
        push(1);  check("wrap_row", s_cur_row);
        push(0);  check("wrap_col", s_cur_col);
        push(1);  check("wrap_wrow", w_cur_row);
        rd(0, 31); push(8'h4F); check("wrap_rd031", s_rd_data);

        @(negedge clk);
        clr = 1'b1; wr_valid = 1'b1; wr_data = 8'h5A;
        @(negedge clk);
        clr = 1'b0; wr_valid = 1'b0;
        busy_len(ns, nw, nr);
        push(128); check("clr_busy_s", ns);
        push(128); check("clr_busy_w", nw);
        push(0);   check("clr_ready", nr);
        push(8'h4F); check("clr_last", s_last_char);
        push(0);   check("clr_row", s_cur_row);
        push(0);   check("clr_col", s_cur_col);
        scan_s(bad);
        push(0);   check("clr_cells", bad);

        send(8'h58);
        repeat (3) send(8'h0A);
        push(3);  check("lf_row", s_cur_row);
        push(0);  check("lf_col", s_cur_col);
        send(8'h0A);
        busy_len(ns, nw, nr);
        push(32); check("scr_busy_s", ns);
        push(0);  check("scr_busy_w", nw);
        push(0);  check("scr_ready", nr);
        push(3);  check("scr_row", s_cur_row);
        push(0);  check("scr_col", s_cur_col);
        push(0);  check("wrp_row", w_cur_row);
        push(0);  check("wrp_col", w_cur_col);
        scan_s(bad);
        push(0);  check("scr_cells", bad);
        rd(0, 0); push(8'h58); check("wrp_x", w_rd_data);

        send(8'h59);
        rd(3, 0); push(8'h59); check("scr_map", s_rd_data);
        rd(0, 0); push(8'h59); check("wrp_y", w_rd_data);

        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (9) @(negedge clk);
        push(1);  check("mid_busy", s_busy);
        reset = 1'b0;
        #1;
        push(0);  check("mid_rst_busy", s_busy);
        push(1);  check("mid_rst_ready", s_wr_ready);
        push(0);  check("mid_rst_row", s_cur_row);
        push(0);  check("mid_rst_col", s_cur_col);
        push(0);  check("mid_rst_last", s_last_char);
        push(0);  check("mid_rst_rd", s_rd_data);
        push(0);  check("mid_rst_wbusy", w_busy);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        push(0);  check("post_busy", s_busy);
        rd(0, 0);
        push(8'h20); check("post_rd_s", s_rd_data);
        push(8'h20); check("post_rd_w", w_rd_data);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/text_buffer_ctrl.md
TEXT_BUFFER_CTRL -- requirements
Module: text_buffer_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- COLS, 32, characters per row; 2..256, any value.
- ROWS, 4, rows on screen; 2..64, any value.
- SCROLL, 1, cursor past last row: 1 = scroll, 0 = wrap to row 0.
- Derived: CW = clog2(COLS), RW = clog2(ROWS).

REQ-002 The block SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk, in, 1, system clock, all logic on rising edge.
- reset, in, 1, asynchronous, active-low reset.
- wr_valid, in, 1, character byte offered.
- wr_data, in, 8, character byte.
- wr_ready, out, 1, byte accepted when wr_valid && wr_ready on a rising edge.
- clr, in, 1, one-cycle request to blank screen and home cursor.
- rd_row, in, RW, display row (0 = top of screen).
- rd_col, in, CW, display column.
- rd_data, out, 8, character at (rd_row, rd_col).
- cur_row, out, RW, cursor display row.
- cur_col, out, CW, cursor column.
- last_char, out, 8, most recently accepted byte (for 7-seg).
- busy, out, 1, clear or scroll-fill in progress.

Function
REQ-003 Storage SHALL be COLS*ROWS bytes, indexed by physical row and column; wr_ready SHALL equal !busy.
REQ-004 Accepted bytes SHALL be decoded as follows:
- Printable (0x20..0x7E): written at the cursor, then the cursor advances one column.
- 0x0D: column set to 0.
- 0x0A: line feed, REQ-006.
- 0x08: if column > 0, decrement column and write 0x20 at the new position; at column 0, no effect.
- Any other byte: not stored, cursor unchanged.
- In every case, last_char is updated.
REQ-005 When a printable byte is written at column COLS-1, the column SHALL return to 0 and a line feed SHALL follow in the same cycle.
REQ-006 Line feed below row ROWS-1:
- Otherwise, the row is incremented.
- At row ROWS-1 with SCROLL=0: the row becomes 0 and no cells are cleared.
- At row ROWS-1 with SCROLL=1: the row stays ROWS-1, top_ptr advances modulo ROWS, and the new bottom physical row is filled with 0x20.
REQ-007 The scroll fill SHALL take exactly COLS cycles, one cell per cycle, with busy high for those cycles.
REQ-008 Display-to-physical mapping SHALL be phys_row = (display_row + top_ptr) mod ROWS, computed by compare-and-subtract (no divider); top_ptr SHALL stay 0 when SCROLL=0.
REQ-009 rd_data SHALL be registered with 1-cycle latency from rd_row/rd_col. A read of a cell written in the same cycle SHALL return the old value.
REQ-010 clr SHALL behave as follows:
- If clr is asserted while !busy: fill all cells with 0x20, one per cycle, over COLS*ROWS cycles, with busy high; then set top_ptr=0 and cursor=(0,0).
- If clr and wr_valid are high in the same cycle: clr wins and the byte is not accepted.
- clr asserted while busy: ignored.
REQ-011 The state machine SHALL have the states IDLE, FILL_ROW and FILL_ALL:
- IDLE -> FILL_ROW on a scrolling line feed.
- IDLE -> FILL_ALL on clr.
- Each FILL state returns to IDLE after its last cell, with busy dropping the cycle after the last write.
REQ-012 Cursor and fill counters SHALL wrap by explicit compare against COLS-1 and ROWS-1, never by natural overflow.

Reset
REQ-013 While reset=0, these outputs SHALL be forced asynchronously: cursor=(0,0), top_ptr=0, last_char=0x00, busy=0, wr_ready=1, rd_data=0x00, state=IDLE.
REQ-014 Storage contents SHALL NOT be cleared by reset.
REQ-015 Reset asserted mid-fill SHALL abort the fill; cells already written keep 0x20, and the remaining cells are unspecified.
REQ-016 Reset release SHALL be synchronous to clk, with the first write accepted on the second rising edge after release.

Verification
REQ-017 Printable write: reset, then send "AB" (0x41, 0x42). Required: reading (0,0) gives 0x41 one cycle later, (0,1) gives 0x42, cursor=(0,2), last_char=0x42.
REQ-018 Line wrap: send 32 printable bytes. Required: cursor=(1,0) and busy stays 0.
REQ-019 Scroll: with SCROLL=1, send 0x0A four times after writing 'X' at (0,0). Required:
- busy=1 for exactly 32 cycles and wr_ready=0 during them.
- Then display row 3 reads all 0x20 and the original 'X' is no longer visible on display rows 0..3.
- Cursor=(3,0).
REQ-020 Wrap mode: repeat REQ-019 with SCROLL=0. Required: no busy pulse, cursor=(0,0), 'X' still at (0,0).
REQ-021 Backspace and CR: send "AB", 0x08, 0x0D. Required: (0,1) holds 0x20, (0,0) holds 0x41, cursor=(0,0). A further 0x08 leaves everything unchanged.
REQ-022 Clear, collision and reset mid-fill: assert clr and wr_valid together. Required:
- busy for 128 cycles, the byte is not accepted, then all cells 0x20 and cursor=(0,0).
- Repeat with reset=0 at fill cycle 10: busy=0 immediately and cursor=(0,0).
